// File: rtl/lcd_lvds_pixel_mapper.sv
// Packs an RGB888 + sync pixel stream into 7:1 LVDS lane words (4 lanes x 7 bits per link).
// Single link emits one word per pixel; dual link pairs pixels and realigns the pair at line start.
module lcd_lvds_pixel_mapper #(
    parameter int          NUM_LINKS = 2,
    parameter logic [27:0] IDLE_WORD = 28'h080C101
) (
    input  logic                      px_clk,
    input  logic                      px_reset,
    input  logic [1:0]                fmt_req,
    input  logic                      pix_valid,
    input  logic                      lcd_hs,
    input  logic                      lcd_vs,
    input  logic                      lcd_de,
    input  logic [23:0]               lcd_rgb,
    output logic [28*NUM_LINKS-1:0]   lvds_data,
    output logic                      lvds_valid,
    output logic [1:0]                fmt_active,
    output logic                      align_err
);

    typedef enum logic [1:0] {
        FMT_VESA     = 2'b00,
        FMT_JEIDA    = 2'b01,
        FMT_18BPP    = 2'b10,
        FMT_VESA_ALT = 2'b11
    } fmt_e;

    // Lane n occupies word bits [7n+6:7n]; the first-listed bit of each lane is bit 6.
    function automatic logic [27:0] map_pixel(input fmt_e fmt, input logic [23:0] rgb,
                                              input logic hs, input logic vs, input logic de);
        logic [7:0] r, g, b;
        logic [6:0] l0, l1, l2, l3;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        case (fmt)
            FMT_JEIDA, FMT_18BPP: begin
                l0 = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
                l1 = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
                l2 = {b[4], b[5], b[6], b[7], hs, vs, de};
                l3 = (fmt == FMT_JEIDA) ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0} : 7'h00;
            end
            default: begin
                l0 = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
                l1 = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
                l2 = {b[2], b[3], b[4], b[5], hs, vs, de};
                l3 = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
            end
        endcase
        return {l3, l2, l1, l0};
    endfunction

    fmt_e        fmt_q;
    logic        vs_q;
    logic        de_q;
    logic [27:0] word;
    logic        de_rise;

    // The mapping always uses the registered format, so the vs-edge pixel keeps the old one.
    assign word    = map_pixel(fmt_q, lcd_rgb, lcd_hs, lcd_vs, lcd_de);
    assign de_rise = lcd_de && !de_q;

    always_ff @(posedge px_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (px_reset) begin
            fmt_q <= fmt_e'(fmt_req);
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
        end else if (pix_valid) begin
            if (lcd_vs && !vs_q) begin
                fmt_q <= fmt_e'(fmt_req);
            end
            vs_q <= lcd_vs;
            de_q <= lcd_de;
        end
    end

    assign fmt_active = fmt_q;

    generate
        if (NUM_LINKS == 1) begin : g_single
            logic [27:0] data_q;
            logic        valid_q;

            always_ff @(posedge px_clk) begin
                if (px_reset) begin
                    data_q  <= IDLE_WORD;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= pix_valid;
                    if (pix_valid) begin
                        data_q <= word;
                    end
                end
            end

            assign lvds_data  = data_q;
            assign lvds_valid = valid_q;
            assign align_err  = 1'b0;
        end else begin : g_dual
            typedef enum logic {
                GATHER_A = 1'b0,
                GATHER_B = 1'b1
            } state_e;

            state_e      state_q;
            logic [27:0] hold_q;
            logic [55:0] data_q;
            logic        valid_q;
            logic        align_q;

            always_ff @(posedge px_clk) begin
                if (px_reset) begin
                    state_q <= GATHER_A;
                    hold_q  <= '0;
                    data_q  <= {IDLE_WORD, IDLE_WORD};
                    valid_q <= 1'b0;
                    align_q <= 1'b0;
                end else begin
                    valid_q <= 1'b0;
                    align_q <= 1'b0;
                    if (pix_valid) begin
                        case (state_q)
                            GATHER_A: begin
                                hold_q  <= word;
                                state_q <= GATHER_B;
                            end
                            default: begin
                                valid_q <= 1'b1;
                                if (de_rise) begin
                                    // Odd blanking count: flush the stray pixel on both links so
                                    // the first active pixel starts a fresh pair on link0.
                                    data_q  <= {hold_q, hold_q};
                                    align_q <= 1'b1;
                                    hold_q  <= word;
                                end else begin
                                    data_q  <= {word, hold_q};
                                    state_q <= GATHER_A;
                                end
                            end
                        endcase
                    end
                end
            end

            assign lvds_data  = data_q;
            assign lvds_valid = valid_q;
            assign align_err  = align_q;
        end
    endgenerate

endmodule
